// File: rtl/dp_operand_sequencer.sv
// Valid/ready front and back end for a registered 3-operand datapath.
// Launches one operand triple, waits out the datapath latency, then holds the captured x/z until accepted.
module dp_operand_sequencer #(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned DP_LATENCY = 1,
    parameter int unsigned CNTWIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_b,
    input  logic [DATAWIDTH-1:0] in_c,
    output logic [DATAWIDTH-1:0] dp_a,
    output logic [DATAWIDTH-1:0] dp_b,
    output logic [DATAWIDTH-1:0] dp_c,
    input  logic [DATAWIDTH-1:0] dp_x,
    input  logic [DATAWIDTH-1:0] dp_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_x,
    output logic [DATAWIDTH-1:0] out_z,
    output logic                 busy,
    output logic [CNTWIDTH-1:0]  txn_count
);

    localparam int unsigned LATW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY + 1) : 1;
    localparam logic [LATW-1:0] LAT_INIT = LATW'(DP_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LATW-1:0]       cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]  dp_a_q, dp_a_d;
    logic [DATAWIDTH-1:0]  dp_b_q, dp_b_d;
    logic [DATAWIDTH-1:0]  dp_c_q, dp_c_d;
    logic [DATAWIDTH-1:0]  out_x_q, out_x_d;
    logic [DATAWIDTH-1:0]  out_z_q, out_z_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNTWIDTH-1:0]   txn_q, txn_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_c_q      <= '0;
            out_x_q     <= '0;
            out_z_q     <= '0;
            out_valid_q <= 1'b0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_c_q      <= dp_c_d;
            out_x_q     <= out_x_d;
            out_z_q     <= out_z_d;
            out_valid_q <= out_valid_d;
            txn_q       <= txn_d;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_c_d      = dp_c_q;
        out_x_d     = out_x_q;
        out_z_d     = out_z_q;
        out_valid_d = out_valid_q;
        txn_d       = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dp_a_d  = in_a;
                    dp_b_d  = in_b;
                    dp_c_d  = in_c;
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // dp_x/dp_z are only trusted once the latency count has drained
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LATW'(1);
                end else begin
                    out_x_d     = dp_x;
                    out_z_d     = dp_z;
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    txn_d       = txn_q + CNTWIDTH'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_c      = dp_c_q;
    assign out_x     = out_x_q;
    assign out_z     = out_z_q;
    assign out_valid = out_valid_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_dp_operand_sequencer.sv
// Bench for dp_operand_sequencer driving a Circuit_2-style registered datapath (latency 1).
// Directed vectors, back-pressure/reset corner cases, wrap of a 4-bit counter and a randomized run.
module tb_dp_operand_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a, in_b, in_c;
    logic [DW-1:0] dp_a, dp_b, dp_c;
    logic [DW-1:0] dp_x, dp_z;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_x, out_z;
    logic          busy;
    logic [CW-1:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;
    int e        = 0;
    int acc_edge = 0;
    logic [CW-1:0] m_cnt;

    dp_operand_sequencer #(.DATAWIDTH(DW), .DP_LATENCY(1), .CNTWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_x(dp_x), .dp_z(dp_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_z(out_z),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Circuit_2 behaviour: d=a+b, e=a+c, f=a-b; x=g<<(d<e), z=h>>(d==e)
    function automatic logic [63:0] circuit2(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        logic [31:0] d, ee, f, g, h;
        logic lt, eq;
        d  = a + b;
        ee = a + c;
        f  = a - b;
        lt = d < ee;
        eq = d == ee;
        g  = lt ? ee : d;
        h  = eq ? f : g;
        return {g << lt, h >> eq};
    endfunction

    // Datapath under the sequencer: one register stage, reset shared
    always_ff @(posedge clk) begin
        if (rst) {dp_x, dp_z} <= '0;
        else     {dp_x, dp_z} <= circuit2(dp_a, dp_b, dp_c);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, act, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    // One full transaction; hold = cycles of out_ready=0 while the result is presented
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] ex, input logic [31:0] ez, input int hold);
        int waited;
        in_a = a; in_b = b; in_c = c;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        acc_edge = e;
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("dp_a_launch", dp_a, a);
        chk("dp_c_launch", dp_c, c);
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        chk("result_latency", 32'(waited), 32'd2);
        chk("out_x", out_x, ex);
        chk("out_z", out_z, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = a ^ 32'hDEAD_BEEF; in_b = ~b; in_c = c + 32'd7;
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_x", out_x, ex);
            chk("bp_out_z", out_z, ez);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_dp_a_held", dp_a, a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        m_cnt = m_cnt + CW'(1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_txn_count", 32'(txn_count), 32'(m_cnt));
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [31:0] a, b, c, x, z;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev;
        int pend;
        logic m_busy;
        int m_acc;
        logic [31:0] m_x, m_z, m_dpa;
        logic [63:0] r;
        logic exp_ov;

        vecs[0] = '{a: 32'd5,  b: 32'd3, c: 32'd1, x: 32'd8,  z: 32'd8,          hold: 0};
        vecs[1] = '{a: 32'd2,  b: 32'd3, c: 32'd4, x: 32'd12, z: 32'd6,          hold: 0};
        vecs[2] = '{a: 32'd1,  b: 32'd2, c: 32'd2, x: 32'd3,  z: 32'h7FFF_FFFF,  hold: 0};
        vecs[3] = '{a: 32'd7,  b: 32'd9, c: 32'd2, x: 32'd16, z: 32'd16,         hold: 5};
        vecs[4] = '{a: 32'd10, b: 32'd1, c: 32'd1, x: 32'd11, z: 32'd4,          hold: 0};
        vecs[5] = '{a: 32'd0,  b: 32'd0, c: 32'd0, x: 32'd0,  z: 32'd0,          hold: 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        m_cnt = '0;

        // Reset held for two cycles
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        tick();
        chk("rst_in_ready2", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        chk("rst_dp_a", dp_a, 32'd0);
        chk("rst_dp_b", dp_b, 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_z", out_z, 32'd0);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].z, vecs[i].hold);

        // Reset while waiting on the datapath aborts the transaction
        in_a = 32'd5; in_b = 32'd3; in_c = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("abort_busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        m_cnt = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_txn_count", 32'(txn_count), 32'd0);
        chk("abort_dp_a", dp_a, 32'd0);
        tick(); tick(); tick();
        chk("abort_no_result", 32'(out_valid), 32'd0);
        chk("abort_count_held", 32'(txn_count), 32'd0);
        run_txn(32'd2, 32'd3, 32'd4, 32'd12, 32'd6, 0);

        // Back-to-back with a 4-bit count: wraps 15 -> 0 -> 1
        m_dpa = '0;
        prev  = 0;
        for (int i = 0; i < 17; i++) begin
            logic [31:0] a, b, c;
            a = $urandom_range(0, 200); b = $urandom_range(0, 200);
            c = (i % 3 == 0) ? b : $urandom_range(0, 200);
            r = circuit2(a, b, c);
            run_txn(a, b, c, r[63:32], r[31:0], 0);
            if (i > 0) chk("throughput", 32'(acc_edge - prev), 32'd4);
            prev  = acc_edge;
            m_dpa = a;
        end

        // Randomized handshakes against an edge-timestamp model
        m_busy = 1'b0; m_acc = 0; m_x = '0; m_z = '0; pend = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
            in_b = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
            in_c = ($urandom_range(0, 3) == 0) ? in_b : $urandom;
            exp_ov = m_busy && (e >= m_acc + 2);
            if (!m_busy && in_valid) begin
                m_busy = 1'b1;
                m_acc  = e + 1;
                r      = circuit2(in_a, in_b, in_c);
                m_x    = r[63:32];
                m_z    = r[31:0];
                m_dpa  = in_a;
            end else if (exp_ov && out_ready) begin
                m_busy = 1'b0;
                m_cnt  = m_cnt + CW'(1);
            end
            tick();
            exp_ov = m_busy && (e >= m_acc + 2);
            chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
            chk("rnd_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_txn_count", 32'(txn_count), 32'(m_cnt));
            chk("rnd_dp_a", dp_a, m_dpa);
            if (exp_ov) begin
                chk("rnd_out_x", out_x, m_x);
                chk("rnd_out_z", out_z, m_z);
                pend++;
            end
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
